core_io_top: RTL and testbench

- Board-level I/O top: divides the system clock into cpu_clk, receives PS/2 keyboard frames, and presents received scan codes on the 8 LEDs and the 4-digit multiplexed 7-segment display.
- Generates 640x480 VGA sync and colour.
- Sits directly under the FPGA pin wrapper; all outputs are registered.

---
 rtl/core_io_pkg.sv | 51 +++++
 rtl/ps2_rx.sv | 98 +++++++++
 rtl/core_io_top.sv | 146 ++++++++++++++
 tb/tb_core_io_top.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_io_pkg
//  Description : Shared types, VGA 640x480 timing constants and hex-to-7seg
//                encoder for the board I/O top.
//  Revision    : 1.0  initial release
// ============================================================================
package core_io_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [9:0] c_H_ACTIVE     = 10'd640;
    localparam logic [9:0] c_H_SYNC_START = 10'd656;
    localparam logic [9:0] c_H_SYNC_END   = 10'd752;
    localparam logic [9:0] c_H_TOTAL      = 10'd800;
    localparam logic [9:0] c_V_ACTIVE     = 10'd480;
    localparam logic [9:0] c_V_SYNC_START = 10'd490;
    localparam logic [9:0] c_V_SYNC_END   = 10'd492;
    localparam logic [9:0] c_V_TOTAL      = 10'd525;

    // Active-low segments {dp,g,f,e,d,c,b,a}; dp always off
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nibble);
        logic [7:0] seg;
        case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 frame receiver: input synchronizer, falling-edge
//                detect, frame FSM and odd-parity/stop check.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx
    import core_io_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_valid
);

    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;
    ps2_state_t r_state, w_state_next;
    logic [2:0] r_bit_idx, w_bit_idx_next;
    logic [7:0] r_shift, w_shift_next;
    logic       r_parity, w_parity_next;
    logic       w_fall, w_bit, w_accept;

    // Clock and data see identical sync delay, so data is valid on the edge cycle
    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_bit  = r_data_sync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_accept       = 1'b0;
        if (w_fall) begin
            case (r_state)
                PS2_IDLE: begin
                    if (!w_bit) begin
                        w_state_next   = PS2_DATA;
                        w_bit_idx_next = 3'd0;
                    end
                end
                PS2_DATA: begin
                    w_shift_next   = {w_bit, r_shift[7:1]};
                    w_bit_idx_next = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = PS2_PARITY;
                    end
                end
                PS2_PARITY: begin
                    w_parity_next = w_bit;
                    w_state_next  = PS2_STOP;
                end
                default: begin
                    w_accept     = w_bit & (^{r_shift, r_parity});
                    w_state_next = PS2_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= PS2_IDLE;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_parity  <= 1'b0;
            o_byte    <= 8'h00;
            o_valid   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            o_valid   <= w_accept;
            if (w_accept) begin
                o_byte <= r_shift;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_io_top.sv
`default_nettype none
// ============================================================================
//  Module      : core_io_top
//  Description : Board I/O top: cpu clock divider, PS/2 scan-code capture to
//                LEDs and 4-digit 7-seg, 640x480 VGA sync and pattern.
//  Revision    : 1.0  initial release
// ============================================================================
module core_io_top
    import core_io_pkg::*;
#(
    parameter int CPU_DIV      = 1,
    parameter int SEG_DIV_BITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] SW,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] led_data,
    output logic [7:0] segment_data,
    output logic [3:0] AN,
    output logic [2:0] r,
    output logic [2:0] g,
    output logic [1:0] b,
    output logic       hs,
    output logic       vs,
    output logic       cpu_clk
);

    // Counter restarts after 2^(CPU_DIV-1) cycles so CPU_DIV=1 yields clk/2
    localparam logic [CPU_DIV-1:0] c_DIV_LAST = CPU_DIV'((1 << (CPU_DIV - 1)) - 1);

    logic [CPU_DIV-1:0]      r_div_cnt;
    logic [7:0]              w_rx_byte;
    logic                    w_rx_valid;
    logic [7:0]              r_last_byte;
    logic [15:0]             r_disp;
    logic [7:0]              r_rx_count;
    logic [SEG_DIV_BITS-1:0] r_seg_cnt;
    logic [1:0]              w_sel;
    logic [3:0]              w_nibble;
    logic                    r_pix_en;
    logic [9:0]              r_h;
    logic [9:0]              r_v;
    logic                    w_active;
    logic [7:0]              w_rgb;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            cpu_clk   <= 1'b0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
            cpu_clk   <= ~cpu_clk;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    ps2_rx u_ps2_rx (
        .clk        (clk),
        .rst        (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_byte     (w_rx_byte),
        .o_valid    (w_rx_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_byte <= 8'h00;
            r_disp      <= 16'h0000;
            r_rx_count  <= 8'h00;
            led_data    <= 8'h00;
        end else begin
            if (w_rx_valid) begin
                r_last_byte <= w_rx_byte;
                r_disp      <= {r_disp[7:0], w_rx_byte};
                r_rx_count  <= r_rx_count + 8'd1;
            end
            led_data <= SW[0] ? r_rx_count : r_last_byte;
        end
    end

    assign w_sel    = r_seg_cnt[SEG_DIV_BITS-1 -: 2];
    assign w_nibble = r_disp[{w_sel, 2'b00} +: 4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_cnt    <= '0;
            AN           <= 4'b1110;
            segment_data <= 8'hC0;
        end else begin
            r_seg_cnt    <= r_seg_cnt + 1'b1;
            AN           <= ~(4'b0001 << w_sel);
            segment_data <= hex_to_seg(w_nibble);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_en <= 1'b0;
            r_h      <= 10'd0;
            r_v      <= 10'd0;
        end else begin
            r_pix_en <= ~r_pix_en;
            if (r_pix_en) begin
                if (r_h == c_H_TOTAL - 10'd1) begin
                    r_h <= 10'd0;
                    r_v <= (r_v == c_V_TOTAL - 10'd1) ? 10'd0 : r_v + 10'd1;
                end else begin
                    r_h <= r_h + 10'd1;
                end
            end
        end
    end

    assign w_active = (r_h < c_H_ACTIVE) && (r_v < c_V_ACTIVE);

    always_comb begin
        w_rgb = 8'h00;
        if (w_active) begin
            case (SW[2:1])
                // Low byte of h[9:7] repeated eight times
                2'b01:   w_rgb = {r_h[8:7], r_h[9:7], r_h[9:7]};
                2'b10:   w_rgb = r_last_byte;
                2'b11:   w_rgb = 8'hFF;
                default: w_rgb = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {r, g, b} <= 8'h00;
            hs        <= 1'b1;
            vs        <= 1'b1;
        end else begin
            {r, g, b} <= w_rgb;
            hs        <= ~((r_h >= c_H_SYNC_START) && (r_h < c_H_SYNC_END));
            vs        <= ~((r_v >= c_V_SYNC_START) && (r_v < c_V_SYNC_END));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_io_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_core_io_top
//  Description : Randomized self-checking bench for core_io_top against a
//                cycle-count based behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_core_io_top;

    localparam int CPU_DIV      = 1;
    localparam int SEG_DIV_BITS = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] SW = 3'b000;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] led_data;
    logic [7:0] segment_data;
    logic [3:0] AN;
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
    logic       cpu_clk;

    core_io_top #(
        .CPU_DIV      (CPU_DIV),
        .SEG_DIV_BITS (SEG_DIV_BITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .SW           (SW),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .led_data     (led_data),
        .segment_data (segment_data),
        .AN           (AN),
        .r            (r),
        .g            (g),
        .b            (b),
        .hs           (hs),
        .vs           (vs),
        .cpu_clk      (cpu_clk)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [7:0]  seg_lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          m_last  = 0;
    int          m_disp  = 0;
    int          m_count = 0;
    int unsigned cyc     = 0;
    bit          mon_en  = 1'b0;
    bit          quiet   = 1'b0;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Every output is a function of cycles since reset and the model registers
    always @(negedge clk) begin
        int p, h, v, sel, t;
        logic [7:0] rgb_exp;
        if (mon_en && cyc != 0) begin
            t   = 1 << (CPU_DIV - 1);
            p   = int'((cyc - 1) / 2);
            h   = p % 800;
            v   = (p / 800) % 525;
            sel = int'(((cyc - 1) >> (SEG_DIV_BITS - 2)) % 4);
            check("cpu_clk", cpu_clk, (cyc / t) % 2);
            check("hs", hs, (h >= 656 && h < 752) ? 0 : 1);
            check("vs", vs, (v >= 490 && v < 492) ? 0 : 1);
            check("an", AN, ~(1 << sel) & 15);
            if (quiet) begin
                check("seg", segment_data, seg_lut[(m_disp >> (4 * sel)) & 15]);
                check("led", led_data, SW[0] ? m_count : m_last);
                rgb_exp = 8'h00;
                if (h < 640 && v < 480) begin
                    case (SW[2:1])
                        2'b01:   rgb_exp = 8'(((h >> 7) * 32'h249249) & 255);
                        2'b10:   rgb_exp = 8'(m_last);
                        2'b11:   rgb_exp = 8'hFF;
                        default: rgb_exp = 8'h00;
                    endcase
                end
                check("rgb", {r, g, b}, rgb_exp);
            end
        end
    end

    task automatic ps2_bit(input logic d, input int half);
        ps2_clk  = 1'b1;
        ps2_data = d;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_err, input logic stop, input int half);
        logic par;
        par   = ~(^d) ^ par_err;
        quiet = 1'b0;
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(d[i], half);
        ps2_bit(par, half);
        ps2_bit(stop, half);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        if (stop && !par_err) begin
            m_last  = d;
            m_disp  = ((m_disp << 8) | d) & 16'hFFFF;
            m_count = (m_count + 1) % 256;
        end
        repeat (8) @(negedge clk);
        quiet = 1'b1;
    endtask

    task automatic set_sw(input logic [2:0] v);
        quiet = 1'b0;
        SW    = v;
        repeat (3) @(negedge clk);
        quiet = 1'b1;
    endtask

    task automatic measure_hs();
        int n, low_w, per;
        n = 0;
        while (hs !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        while (hs !== 1'b0 && n < 4000) begin @(negedge clk); n++; end
        check("hs_found", n < 4000, 1);
        check("rgb_in_sync", {r, g, b}, 8'h00);
        low_w = 0;
        while (hs === 1'b0 && low_w < 4000) begin @(negedge clk); low_w++; end
        per = low_w;
        while (hs === 1'b1 && per < 4000) begin @(negedge clk); per++; end
        check("hs_low_width", low_w, 192);
        check("hs_period", per, 1600);
        repeat (300) @(negedge clk);
        check("vga_r", r, 0);
        check("vga_g", g, 5);
        check("vga_b", b, 2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_digit [4];
        exp_digit = '{8'h82, 8'hF9, 8'hC0, 8'h8E};

        repeat (2) @(negedge clk);
        check("rst_cpu_clk", cpu_clk, 0);
        check("rst_led", led_data, 8'h00);
        check("rst_an", AN, 4'b1110);
        check("rst_seg", segment_data, 8'hC0);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_rgb", {r, g, b}, 8'h00);
        rst    = 1'b0;
        mon_en = 1'b1;
        quiet  = 1'b1;

        // Idle edges with data high must not start a frame
        ps2_bit(1'b1, 2);
        ps2_bit(1'b1, 2);
        send_frame(8'h16, 1'b0, 1'b1, 2);
        check("led_first", led_data, 8'h16);
        set_sw(3'b001);
        check("count_first", led_data, 8'h01);
        set_sw(3'b000);

        send_frame(8'hF0, 1'b0, 1'b1, 2);
        send_frame(8'h16, 1'b0, 1'b1, 2);
        for (int i = 0; i < 4; i++) begin
            int n;
            logic [3:0] an_exp;
            an_exp = ~(4'b0001 << i);
            n = 0;
            while (AN !== an_exp && n < 200) begin @(negedge clk); n++; end
            check("scan_an", AN, an_exp);
            check("scan_seg", segment_data, exp_digit[i]);
        end
        set_sw(3'b001);
        check("count_three", led_data, 8'h03);

        send_frame(8'h5A, 1'b1, 1'b1, 2);
        send_frame(8'h5A, 1'b0, 1'b0, 2);
        check("count_after_bad", led_data, 8'h03);
        set_sw(3'b000);
        check("led_after_bad", led_data, 8'h16);

        // Reset in the middle of a frame discards it
        quiet = 1'b0;
        ps2_bit(1'b0, 2);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 2);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        rst      = 1'b1;
        m_last   = 0;
        m_disp   = 0;
        m_count  = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        quiet = 1'b1;
        send_frame(8'h16, 1'b0, 1'b1, 2);
        check("led_after_rst", led_data, 8'h16);
        set_sw(3'b001);
        check("count_after_rst", led_data, 8'h01);

        for (int k = 0; k < 24; k++) begin
            logic [7:0] d;
            logic pe, st;
            int half;
            d    = 8'($urandom);
            pe   = ($urandom_range(3) == 0);
            st   = ($urandom_range(7) != 0);
            half = $urandom_range(1, 2);
            send_frame(d, pe, st, half);
            if (k % 6 == 5) set_sw(3'($urandom));
        end
        check("led_random", led_data, 8'(SW[0] ? m_count : m_last));

        set_sw(3'b000);
        send_frame(8'h16, 1'b0, 1'b1, 1);
        set_sw(3'b100);
        measure_hs();
        set_sw(3'b010);
        repeat (1700) @(negedge clk);
        set_sw(3'b110);
        repeat (1700) @(negedge clk);
        set_sw(3'b000);
        repeat (1700) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
